// File: rtl/pi_channel_scheduler_if.sv
// Bus bundle for the four-channel PI scheduler: sample requests/grants,
// gain configuration, clear lines and the result stream.
interface pi_channel_scheduler_if;
  // Handshake: a channel raises req[c] and holds it (with a stable err slice)
  // until ack[c] pulses for one cycle; err is captured on that same edge.
  // out_valid is a one-cycle strobe with no back-pressure.
  logic [3:0]   req;
  logic [127:0] err;
  logic [3:0]   ack;
  logic [3:0]   clr;
  logic         cfg_we;
  logic [1:0]   cfg_ch;
  logic [31:0]  cfg_kp;
  logic [31:0]  cfg_ki;
  logic         out_valid;
  logic [1:0]   out_ch;
  logic [31:0]  out_data;

  modport master (
    output req, err, clr, cfg_we, cfg_ch, cfg_kp, cfg_ki,
    input  ack, out_valid, out_ch, out_data
  );

  modport slave (
    input  req, err, clr, cfg_we, cfg_ch, cfg_kp, cfg_ki,
    output ack, out_valid, out_ch, out_data
  );
endinterface

// File: rtl/pi_channel_scheduler.sv
// Four-channel PI controller sharing one multiply/accumulate datapath,
// round-robin arbitrated, one sample every four cycles at best.
module pi_channel_scheduler #(
  parameter logic [31:0] KP_RESET = 32'h0000_1999,
  parameter logic [31:0] KI_RESET = 32'h0064_0000,
  parameter logic [31:0] INT_LIM  = 32'h7FFF_FFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  pi_channel_scheduler_if.slave   bus,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic signed [32:0] LIM_POS = $signed({1'b0, INT_LIM});
  localparam logic signed [32:0] LIM_NEG = -LIM_POS;

  state_t state_q, state_d;

  logic signed [31:0] kp_q    [4];
  logic signed [31:0] ki_q    [4];
  logic signed [31:0] integ_q [4];

  logic [1:0]         last_q;
  logic [1:0]         ch_q;
  logic signed [31:0] err_q, kpc_q, kic_q;
  logic signed [31:0] p_q, inc_q, integ_new_q;

  logic               out_valid_q;
  logic [1:0]         out_ch_q;
  logic [31:0]        out_data_q;

  logic [3:0]         grant_oh;
  logic [1:0]         grant_ch;
  logic               grant_any;
  logic               take;

  logic signed [31:0] p_d, inc_d, integ_new_d, out_d;
  logic signed [32:0] acc_sum, out_sum;

  // (a*b)>>>16 from a full 64-bit product, saturated to 32 bits.
  function automatic logic signed [31:0] mul_q16(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
    logic signed [63:0] prod;
    logic signed [63:0] sh;
    prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    sh   = prod >>> 16;
    if (sh > 64'sh0000_0000_7FFF_FFFF)
      return 32'sh7FFF_FFFF;
    else if (sh < 64'shFFFF_FFFF_8000_0000)
      return 32'sh8000_0000;
    else
      return sh[31:0];
  endfunction

  // Round-robin: the first requester after the last granted channel wins.
  always_comb begin
    grant_oh  = 4'b0000;
    grant_ch  = 2'd0;
    grant_any = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!grant_any && bus.req[last_q + 2'(i)]) begin
        grant_any = 1'b1;
        grant_ch  = last_q + 2'(i);
        grant_oh  = 4'b0001 << (last_q + 2'(i));
      end
    end
  end

  assign take    = (state_q == IDLE) && grant_any && !rst;
  assign bus.ack = take ? grant_oh : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = MUL;
      MUL:     state_d = ACC;
      ACC:     state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state = state_q;

  assign p_d   = mul_q16(err_q, kpc_q);
  assign inc_d = mul_q16(err_q, kic_q);

  assign acc_sum = $signed({integ_q[ch_q][31], integ_q[ch_q]}) + $signed({inc_q[31], inc_q});
  assign integ_new_d = (acc_sum > LIM_POS) ? LIM_POS[31:0] :
                       (acc_sum < LIM_NEG) ? LIM_NEG[31:0] : acc_sum[31:0];

  assign out_sum = $signed({p_q[31], p_q}) + $signed({integ_new_q[31], integ_new_q});
  assign out_d   = (out_sum[32] != out_sum[31]) ?
                   (out_sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF) : out_sum[31:0];

  // Sample pipeline and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= 2'd3;
      ch_q        <= 2'd0;
      err_q       <= '0;
      kpc_q       <= '0;
      kic_q       <= '0;
      p_q         <= '0;
      inc_q       <= '0;
      integ_new_q <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= 2'd0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (take) begin
        last_q <= grant_ch;
        ch_q   <= grant_ch;
        err_q  <= bus.err[{grant_ch, 5'd0} +: 32];
        kpc_q  <= kp_q[grant_ch];
        kic_q  <= ki_q[grant_ch];
      end
      if (state_q == MUL) begin
        p_q   <= p_d;
        inc_q <= inc_d;
      end
      if (state_q == ACC) integ_new_q <= integ_new_d;
      if (state_q == OUT) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= ch_q;
        out_data_q  <= out_d;
      end
    end
  end

  // Gains: a write on the grant edge lands after the grant has sampled the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        kp_q[c] <= KP_RESET;
        ki_q[c] <= KI_RESET;
      end
    end else if (bus.cfg_we) begin
      kp_q[bus.cfg_ch] <= bus.cfg_kp;
      ki_q[bus.cfg_ch] <= bus.cfg_ki;
    end
  end

  // Clear beats the ACC write; the in-flight result still carries integ_new.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (rst || bus.clr[c])
        integ_q[c] <= '0;
      else if (state_q == ACC && ch_q == 2'(c))
        integ_q[c] <= integ_new_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: doc/pi_channel_scheduler.md
PI_CHANNEL_SCHEDULER -- requirements
Module: pi_channel_scheduler

Interface
REQ-001 Parameter KP_RESET, default 32'h0000_1999, reset proportional gain for every channel (signed Q16.16, 0.1).
REQ-002 Parameter KI_RESET, default 32'h0064_0000, reset integral gain for every channel (signed Q16.16, 100.0).
REQ-003 Parameter INT_LIM, default 32'h7FFF_FFFF, positive integrator clamp; the integrator range is [-INT_LIM, +INT_LIM].
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req  in  4  per-channel sample request; held high until the matching ack.
REQ-008 err  in  128  packed signed Q16.16 errors; channel c at bits [32c+31:32c].
REQ-009 ack  out  4  one-hot, one-cycle grant; err of the granted channel is captured on that edge.
REQ-010 clr  in  4  per-channel integrator clear.
REQ-011 cfg_we  in  1  gain write strobe.
REQ-012 cfg_ch  in  2  gain write target channel.
REQ-013 cfg_kp  in  32  signed Q16.16 proportional gain.
REQ-014 cfg_ki  in  32  signed Q16.16 integral gain.
REQ-015 out_valid  out  1  one-cycle result strobe.
REQ-016 out_ch  out  2  channel of the result.
REQ-017 out_data  out  32  signed Q16.16 controller output.

Function
REQ-018 One shared PI datapath SHALL be time-multiplexed across 4 channels; each channel has its own kp, ki and 32-bit signed integrator.
REQ-019 FSM states SHALL be IDLE, MUL, ACC and OUT, visited in that order; each non-IDLE state lasts exactly 1 cycle.
REQ-020 In IDLE with any req high, the block SHALL grant exactly one channel, pulse its ack, capture err, kp and ki for that channel, and go to MUL.
REQ-021 Arbitration SHALL be round-robin: search starts at (last granted channel + 1) mod 4; after reset the last granted channel is 3, so channel 0 has first priority.
REQ-022 In MUL: p = (err*kp)>>>16 and inc = (err*ki)>>>16, each from a 64-bit signed product, arithmetic shift, then saturated to 32-bit signed.
REQ-023 In ACC: integ_new = clamp(integ + inc, -INT_LIM, +INT_LIM); the sum is computed at 33 bits with no wrap; integ_new is written to the channel's integrator.
REQ-024 In OUT: out_data = 32-bit signed saturation of (p + integ_new); out_valid=1 and out_ch=granted channel for that cycle only; next state IDLE.
REQ-025 Latency SHALL be: ack on edge T, out_valid high in the cycle after edge T+3; maximum throughput is one sample per 4 cycles.
REQ-026 ack SHALL never be asserted outside IDLE; req lines arriving while busy wait, and none are lost.
REQ-027 out_data and out_ch SHALL hold their last values while out_valid=0.
REQ-028 cfg_we SHALL update kp/ki of cfg_ch on the next edge; a sample in flight uses the gains captured at its ack.
REQ-029 clr[c] SHALL zero channel c's integrator on the next edge; when clr[c] and the ACC write to c coincide, clear wins, but that sample's out_data still uses integ_new.
REQ-030 cfg_we and ack on the same edge for the same channel: the grant captures the old gains; the new gains apply from the next sample.

Reset
REQ-031 On rst: FSM to IDLE; ack=0, out_valid=0, out_ch=0, out_data=0; all integrators 0; all kp=KP_RESET, ki=KI_RESET; last granted channel = 3.
REQ-032 rst asserted mid-operation SHALL abort the sample with no out_valid and no integrator write; rst SHALL take priority over cfg_we and clr.

Verification
REQ-033 ch0 kp=0x0000_8000, ki=0x0001_0000, err0=0x0001_0000, two requests -> out_data 0x0001_8000, then 0x0002_8000, out_ch=0.
REQ-034 req=4'b1111 held from reset -> ack sequence 0001,0010,0100,1000,0001, ack spacing exactly 4 cycles.
REQ-035 INT_LIM=0x0010_0000, ch1 kp=0, ki=0x0001_0000, err1=0x000C_0000, three samples -> out_data 0x000C_0000, 0x0010_0000, 0x0010_0000.
REQ-036 err=0x8000_0000 with kp=0x7FFF_FFFF -> p saturates; out_data=0x8000_0000, no wrap.
REQ-037 clr[2] pulsed on ch2's ACC cycle, integrator at 0x0003_0000 -> that output uses 0x0003_0000 plus inc; the next sample starts from integrator 0.
REQ-038 rst pulsed during MUL of ch3 -> no out_valid, ch3 integrator=0, gains back to KP_RESET/KI_RESET, next grant goes to ch0 if requesting.
